uart_rx: RTL and testbench
==========================

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state is updated on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-003 SHALL have port RX_in, input, 1 bit: serial line (driven by the UART TX_out); idles high.
REQ-004 SHALL have port par_en, input, 1 bit: 1 = a parity bit follows the data bits.
REQ-005 SHALL have port par_typ, input, 1 bit: 0 = even parity, 1 = odd parity.
REQ-006 SHALL have port prescale, input, 6 bits: clocks per serial bit; the value 0 is treated as 1.
REQ-007 SHALL have port p_data, output, 8 bits: last correctly received byte.
REQ-008 SHALL have port data_valid, output, 1 bit: one-cycle pulse marking a new value on p_data.
REQ-009 SHALL have port par_err, output, 1 bit: one-cycle pulse when the received parity bit is wrong.
REQ-010 SHALL have port stop_err, output, 1 bit: one-cycle pulse when the stop bit samples 0.
REQ-011 SHALL have port busy, output, 1 bit: high in every state except IDLE.

Function
REQ-012 SHALL implement FSM states IDLE, START, DATA, PARITY and STOP.
REQ-013 SHALL leave IDLE on the first edge at which the sampled RX_in is 0; that edge is cycle 0 of the start bit.
REQ-014 SHALL capture the effective prescale P at the start-detect edge and hold it for the whole frame.
REQ-015 SHALL count bit cycles 0..P-1 and sample each bit once, at cycle S = (P-1)>>1; for P=1, S=0 and the start-detect edge itself validates the start bit.
REQ-016 SHALL treat a start sample of 1 as a glitch: return to IDLE, assert no flags, leave p_data unchanged.
REQ-017 SHALL shift 8 data bits LSB first into an internal register; p_data SHALL NOT change during reception.
REQ-018 SHALL receive one parity bit in PARITY only when par_en=1; when par_en=0, DATA goes directly to STOP.
REQ-019 SHALL compute expected parity as XOR of the 8 data bits XOR par_typ, and compare it with the received parity bit.
REQ-020 SHALL, on a stop sample of 1 with no parity error, register p_data and pulse data_valid for exactly one clock.
REQ-021 SHALL, on a bad frame, pulse par_err and/or stop_err for one clock, keep data_valid=0, and hold p_data.
REQ-022 SHALL register the status pulses at the stop-sample edge and return to IDLE at that same edge, with no idle bit-time required.
REQ-023 SHALL, for P=1 and par_en=1 with start detected at edge k, assert data_valid in the cycle following edge k+10.
REQ-024 SHALL ignore changes on par_en, par_typ and prescale mid-frame; par_en and par_typ are used as sampled at the start-detect edge.
REQ-025 SHALL accept a back-to-back frame whose start bit begins on the cycle after the stop bit.

Reset
REQ-026 SHALL, while rst=0, force state=IDLE, p_data=8'h00, data_valid=0, par_err=0, stop_err=0 and busy=0, and clear all counters.
REQ-027 SHALL, on reset asserted mid-frame, abort the frame with no flags or data_valid, then resume detection in IDLE after release.

Configuration
REQ-028 SHALL, when UART_RX_SYNC_EN is defined, pass RX_in through a two-flop synchronizer preset to 1 by reset; all frame timing is then delayed by 2 clocks.
REQ-029 SHALL, when UART_RX_SYNC_EN is undefined, use RX_in directly with no added latency.

Verification
REQ-030 SHALL cover: P=1, par_en=1, par_typ=0, frame for 8'h32 (start 0, data LSB-first, parity 1, stop 1) -> single data_valid pulse, p_data=8'h32, par_err=0, stop_err=0.
REQ-031 SHALL cover: same frame with parity bit 0 -> par_err pulses once, data_valid stays 0, p_data keeps its previous value.
REQ-032 SHALL cover: P=16, par_en=0, byte 8'hA5 with stop bit 0 -> stop_err pulses once, no data_valid.
REQ-033 SHALL cover: P=16, RX_in low for 3 cycles then high -> busy goes high, then returns to IDLE by cycle 8, no flags.
REQ-034 SHALL cover: P=1, back-to-back frames 8'h01 then 8'hFE -> two data_valid pulses exactly 11 cycles apart, with correct p_data for each.
REQ-035 SHALL cover: rst=0 asserted during the 4th data bit -> all outputs 0 immediately; a following clean 8'h3C frame is received correctly.

Source files
------------

// File: rtl/uart_rx.sv
// UART receiver: start/data/parity/stop framing with a runtime prescale (clocks per bit).
// Define UART_RX_SYNC_EN to insert a two-flop synchronizer on RX_in (adds 2 clocks of latency).
module uart_rx (
    input  logic       clk,
    input  logic       rst,
    input  logic       RX_in,
    input  logic       par_en,
    input  logic       par_typ,
    input  logic [5:0] prescale,
    output logic [7:0] p_data,
    output logic       data_valid,
    output logic       par_err,
    output logic       stop_err,
    output logic       busy
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    function automatic logic xor8(input logic [7:0] d);
        return ^d;
    endfunction

    logic       rx_s;
    state_t     state_q, state_d;
    logic [5:0] cnt_q, cnt_d;
    logic [5:0] p_q, p_d;
    logic [2:0] bit_q, bit_d;
    logic [7:0] shift_q, shift_d;
    logic       pen_q, pen_d;
    logic       ptyp_q, ptyp_d;
    logic       pfail_q, pfail_d;
    logic [7:0] p_data_q, p_data_d;
    logic       dv_q, dv_d;
    logic       pe_q, pe_d;
    logic       se_q, se_d;
    logic       busy_q, busy_d;

    logic [5:0] p_in_s;
    logic [5:0] last_s;
    logic [5:0] samp_s;
    logic       at_samp_s;
    logic       at_last_s;

`ifdef UART_RX_SYNC_EN
    logic [1:0] sync_q;

    // Two-flop synchronizer; preset to the idle level so reset never looks like a start bit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], RX_in};
        end
    end

    assign rx_s = sync_q[1];
`else
    assign rx_s = RX_in;
`endif

    assign p_in_s    = (prescale == 6'd0) ? 6'd1 : prescale;
    assign last_s    = p_q - 6'd1;
    assign samp_s    = {1'b0, last_s[5:1]};
    assign at_samp_s = (cnt_q == samp_s);
    assign at_last_s = (cnt_q == last_s);

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            cnt_q    <= 6'd0;
            p_q      <= 6'd1;
            bit_q    <= 3'd0;
            shift_q  <= 8'h00;
            pen_q    <= 1'b0;
            ptyp_q   <= 1'b0;
            pfail_q  <= 1'b0;
            p_data_q <= 8'h00;
            dv_q     <= 1'b0;
            pe_q     <= 1'b0;
            se_q     <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            p_q      <= p_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            pen_q    <= pen_d;
            ptyp_q   <= ptyp_d;
            pfail_q  <= pfail_d;
            p_data_q <= p_data_d;
            dv_q     <= dv_d;
            pe_q     <= pe_d;
            se_q     <= se_d;
            busy_q   <= busy_d;
        end
    end

    // Next-state logic: bit timing, sampling and frame status.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        p_d      = p_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        pen_d    = pen_q;
        ptyp_d   = ptyp_q;
        pfail_d  = pfail_q;
        p_data_d = p_data_q;
        dv_d     = 1'b0;
        pe_d     = 1'b0;
        se_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (!rx_s) begin
                    // Detect edge is cycle 0 of the start bit; frame settings are frozen here.
                    p_d     = p_in_s;
                    pen_d   = par_en;
                    ptyp_d  = par_typ;
                    pfail_d = 1'b0;
                    bit_d   = 3'd0;
                    if (p_in_s == 6'd1) begin
                        state_d = DATA;
                        cnt_d   = 6'd0;
                    end else begin
                        state_d = START;
                        cnt_d   = 6'd1;
                    end
                end else begin
                    cnt_d = 6'd0;
                end
            end
            START: begin
                if (at_samp_s && rx_s) begin
                    state_d = IDLE;
                    cnt_d   = 6'd0;
                end else if (at_last_s) begin
                    state_d = DATA;
                    cnt_d   = 6'd0;
                end else begin
                    cnt_d = cnt_q + 6'd1;
                end
            end
            DATA: begin
                if (at_samp_s) begin
                    shift_d = {rx_s, shift_q[7:1]};
                end else begin
                    shift_d = shift_q;
                end
                if (at_last_s) begin
                    cnt_d = 6'd0;
                    if (bit_q == 3'd7) begin
                        state_d = pen_q ? PARITY : STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 6'd1;
                end
            end
            PARITY: begin
                if (at_samp_s) begin
                    pfail_d = rx_s ^ xor8(shift_q) ^ ptyp_q;
                end else begin
                    pfail_d = pfail_q;
                end
                if (at_last_s) begin
                    state_d = STOP;
                    cnt_d   = 6'd0;
                end else begin
                    cnt_d = cnt_q + 6'd1;
                end
            end
            STOP: begin
                // Status is resolved at the stop sample; the rest of the stop bit is spent in IDLE.
                if (at_samp_s) begin
                    state_d = IDLE;
                    cnt_d   = 6'd0;
                    se_d    = ~rx_s;
                    pe_d    = pfail_q;
                    dv_d    = rx_s & ~pfail_q;
                    if (rx_s && !pfail_q) begin
                        p_data_d = shift_q;
                    end else begin
                        p_data_d = p_data_q;
                    end
                end else begin
                    cnt_d = cnt_q + 6'd1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 6'd0;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    assign p_data     = p_data_q;
    assign data_valid = dv_q;
    assign par_err    = pe_q;
    assign stop_err   = se_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed self-checking bench for uart_rx (default build, no input synchronizer).
module tb_uart_rx;

    logic       clk = 1'b0;
    logic       rst;
    logic       RX_in;
    logic       par_en;
    logic       par_typ;
    logic [5:0] prescale;
    logic [7:0] p_data;
    logic       data_valid;
    logic       par_err;
    logic       stop_err;
    logic       busy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int dv_cnt = 0;
    int pe_cnt = 0;
    int se_cnt = 0;
    int pd_chg = 0;
    logic [7:0] pd_prev = 8'h00;
    logic [7:0] dv_data [0:63];
    int         dv_cyc  [0:63];

    uart_rx dut (
        .clk        (clk),
        .rst        (rst),
        .RX_in      (RX_in),
        .par_en     (par_en),
        .par_typ    (par_typ),
        .prescale   (prescale),
        .p_data     (p_data),
        .data_valid (data_valid),
        .par_err    (par_err),
        .stop_err   (stop_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Pulse monitor: records every status pulse and any p_data change without data_valid.
    always @(negedge clk) begin
        if (rst) begin
            if (data_valid) begin
                if (dv_cnt < 64) begin
                    dv_data[dv_cnt] <= p_data;
                    dv_cyc[dv_cnt]  <= cyc;
                end
                dv_cnt <= dv_cnt + 1;
            end
            if (par_err)  pe_cnt <= pe_cnt + 1;
            if (stop_err) se_cnt <= se_cnt + 1;
            if (!data_valid && (p_data !== pd_prev)) pd_chg <= pd_chg + 1;
        end
        pd_prev <= p_data;
    end

    task automatic idle(input int n);
        RX_in = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input int p, input logic with_par,
                              input logic pbit, input logic sbit, input int stop_len,
                              input logic chg);
        logic       sv_pen;
        logic       sv_ptyp;
        logic [5:0] sv_pre;
        sv_pen  = par_en;
        sv_ptyp = par_typ;
        sv_pre  = prescale;
        RX_in = 1'b0;
        repeat (p) @(negedge clk);
        if (chg) begin
            par_en   = ~par_en;
            par_typ  = ~par_typ;
            prescale = 6'd3;
        end
        for (int i = 0; i < 8; i++) begin
            RX_in = d[i];
            repeat (p) @(negedge clk);
        end
        if (with_par) begin
            RX_in = pbit;
            repeat (p) @(negedge clk);
        end
        RX_in = sbit;
        repeat (stop_len) @(negedge clk);
        RX_in    = 1'b1;
        par_en   = sv_pen;
        par_typ  = sv_ptyp;
        prescale = sv_pre;
    endtask

    task automatic test_reset;
        rst = 1'b0; RX_in = 1'b1; par_en = 1'b0; par_typ = 1'b0; prescale = 6'd1;
        repeat (3) @(negedge clk);
        checks++; if (p_data !== 8'h00)   begin errors++; $display("FAIL reset_p_data got %h exp 00", p_data); end
        checks++; if (data_valid !== 1'b0) begin errors++; $display("FAIL reset_dv got %b exp 0", data_valid); end
        checks++; if (par_err !== 1'b0)    begin errors++; $display("FAIL reset_pe got %b exp 0", par_err); end
        checks++; if (stop_err !== 1'b0)   begin errors++; $display("FAIL reset_se got %b exp 0", stop_err); end
        checks++; if (busy !== 1'b0)       begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
        rst = 1'b1;
        idle(3);
    endtask

    task automatic test_good_p1;
        int b_dv, b_pe, b_se, c0;
        prescale = 6'd1; par_en = 1'b1; par_typ = 1'b0;
        b_dv = dv_cnt; b_pe = pe_cnt; b_se = se_cnt; c0 = cyc;
        send_frame(8'h32, 1, 1'b1, 1'b1, 1'b1, 1, 1'b0);
        idle(5);
        checks++; if (dv_cnt - b_dv !== 1) begin errors++; $display("FAIL p1_dv_count got %0d exp 1", dv_cnt - b_dv); end
        checks++; if (pe_cnt - b_pe !== 0) begin errors++; $display("FAIL p1_pe_count got %0d exp 0", pe_cnt - b_pe); end
        checks++; if (se_cnt - b_se !== 0) begin errors++; $display("FAIL p1_se_count got %0d exp 0", se_cnt - b_se); end
        checks++; if (p_data !== 8'h32)    begin errors++; $display("FAIL p1_p_data got %h exp 32", p_data); end
        checks++; if (dv_cyc[b_dv] !== c0 + 11) begin errors++; $display("FAIL p1_latency got %0d exp %0d", dv_cyc[b_dv], c0 + 11); end
    endtask

    task automatic test_par_err;
        int b_dv, b_pe, b_se;
        b_dv = dv_cnt; b_pe = pe_cnt; b_se = se_cnt;
        send_frame(8'h32, 1, 1'b1, 1'b0, 1'b1, 1, 1'b0);
        idle(5);
        checks++; if (pe_cnt - b_pe !== 1) begin errors++; $display("FAIL par_pe_count got %0d exp 1", pe_cnt - b_pe); end
        checks++; if (dv_cnt - b_dv !== 0) begin errors++; $display("FAIL par_dv_count got %0d exp 0", dv_cnt - b_dv); end
        checks++; if (se_cnt - b_se !== 0) begin errors++; $display("FAIL par_se_count got %0d exp 0", se_cnt - b_se); end
        checks++; if (p_data !== 8'h32)    begin errors++; $display("FAIL par_p_data got %h exp 32", p_data); end
    endtask

    task automatic test_stop_err;
        int b_dv, b_pe, b_se;
        prescale = 6'd16; par_en = 1'b0;
        b_dv = dv_cnt; b_pe = pe_cnt; b_se = se_cnt;
        // Stop held low only through its sample cycle so the line does not form a new start bit.
        send_frame(8'hA5, 16, 1'b0, 1'b0, 1'b0, 8, 1'b0);
        idle(40);
        checks++; if (se_cnt - b_se !== 1) begin errors++; $display("FAIL stop_se_count got %0d exp 1", se_cnt - b_se); end
        checks++; if (dv_cnt - b_dv !== 0) begin errors++; $display("FAIL stop_dv_count got %0d exp 0", dv_cnt - b_dv); end
        checks++; if (pe_cnt - b_pe !== 0) begin errors++; $display("FAIL stop_pe_count got %0d exp 0", pe_cnt - b_pe); end
        checks++; if (p_data !== 8'h32)    begin errors++; $display("FAIL stop_p_data got %h exp 32", p_data); end
    endtask

    task automatic test_glitch;
        int b_dv, b_pe, b_se;
        prescale = 6'd16; par_en = 1'b0;
        b_dv = dv_cnt; b_pe = pe_cnt; b_se = se_cnt;
        RX_in = 1'b0;
        @(negedge clk);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL glitch_busy_hi got %b exp 1", busy); end
        repeat (2) @(negedge clk);
        RX_in = 1'b1;
        repeat (4) @(negedge clk);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL glitch_busy_c6 got %b exp 1", busy); end
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL glitch_busy_c7 got %b exp 0", busy); end
        idle(20);
        checks++; if ((dv_cnt - b_dv) + (pe_cnt - b_pe) + (se_cnt - b_se) !== 0) begin
            errors++; $display("FAIL glitch_flags got %0d exp 0", (dv_cnt - b_dv) + (pe_cnt - b_pe) + (se_cnt - b_se));
        end
        checks++; if (p_data !== 8'h32) begin errors++; $display("FAIL glitch_p_data got %h exp 32", p_data); end
    endtask

    task automatic test_midframe_cfg;
        int b_dv, b_pe, b_se;
        prescale = 6'd16; par_en = 1'b0; par_typ = 1'b0;
        b_dv = dv_cnt; b_pe = pe_cnt; b_se = se_cnt;
        send_frame(8'hA5, 16, 1'b0, 1'b0, 1'b1, 16, 1'b1);
        idle(10);
        checks++; if (dv_cnt - b_dv !== 1) begin errors++; $display("FAIL cfg_dv_count got %0d exp 1", dv_cnt - b_dv); end
        checks++; if (p_data !== 8'hA5)    begin errors++; $display("FAIL cfg_p_data got %h exp a5", p_data); end
        checks++; if ((pe_cnt - b_pe) + (se_cnt - b_se) !== 0) begin
            errors++; $display("FAIL cfg_flags got %0d exp 0", (pe_cnt - b_pe) + (se_cnt - b_se));
        end
    endtask

    task automatic test_back_to_back;
        int b_dv, c0;
        prescale = 6'd1; par_en = 1'b1; par_typ = 1'b0;
        b_dv = dv_cnt; c0 = cyc;
        send_frame(8'h01, 1, 1'b1, 1'b1, 1'b1, 1, 1'b0);
        send_frame(8'hFE, 1, 1'b1, 1'b1, 1'b1, 1, 1'b0);
        idle(5);
        checks++; if (dv_cnt - b_dv !== 2) begin errors++; $display("FAIL b2b_dv_count got %0d exp 2", dv_cnt - b_dv); end
        checks++; if (dv_data[b_dv] !== 8'h01)     begin errors++; $display("FAIL b2b_data0 got %h exp 01", dv_data[b_dv]); end
        checks++; if (dv_data[b_dv + 1] !== 8'hFE) begin errors++; $display("FAIL b2b_data1 got %h exp fe", dv_data[b_dv + 1]); end
        checks++; if (dv_cyc[b_dv + 1] - dv_cyc[b_dv] !== 11) begin
            errors++; $display("FAIL b2b_spacing got %0d exp 11", dv_cyc[b_dv + 1] - dv_cyc[b_dv]);
        end
        checks++; if (dv_cyc[b_dv] !== c0 + 11) begin errors++; $display("FAIL b2b_first got %0d exp %0d", dv_cyc[b_dv], c0 + 11); end
    endtask

    task automatic test_reset_mid;
        int b_dv, b_pe, b_se;
        prescale = 6'd4; par_en = 1'b0;
        b_dv = dv_cnt; b_pe = pe_cnt; b_se = se_cnt;
        RX_in = 1'b0; repeat (4) @(negedge clk);
        RX_in = 1'b1; repeat (4) @(negedge clk);
        RX_in = 1'b0; repeat (4) @(negedge clk);
        RX_in = 1'b1; repeat (4) @(negedge clk);
        RX_in = 1'b0; repeat (2) @(negedge clk);
        #1 rst = 1'b0;
        #1;
        checks++; if (busy !== 1'b0)       begin errors++; $display("FAIL rmid_busy got %b exp 0", busy); end
        checks++; if (p_data !== 8'h00)    begin errors++; $display("FAIL rmid_p_data got %h exp 00", p_data); end
        checks++; if ({data_valid, par_err, stop_err} !== 3'b000) begin
            errors++; $display("FAIL rmid_flags got %b exp 000", {data_valid, par_err, stop_err});
        end
        RX_in = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        idle(3);
        checks++; if ((dv_cnt - b_dv) + (pe_cnt - b_pe) + (se_cnt - b_se) !== 0) begin
            errors++; $display("FAIL rmid_abort got %0d exp 0", (dv_cnt - b_dv) + (pe_cnt - b_pe) + (se_cnt - b_se));
        end
        send_frame(8'h3C, 4, 1'b0, 1'b0, 1'b1, 4, 1'b0);
        idle(8);
        checks++; if (dv_cnt - b_dv !== 1) begin errors++; $display("FAIL rmid_dv_count got %0d exp 1", dv_cnt - b_dv); end
        checks++; if (p_data !== 8'h3C)    begin errors++; $display("FAIL rmid_p_data_after got %h exp 3c", p_data); end
        checks++; if ((pe_cnt - b_pe) + (se_cnt - b_se) !== 0) begin
            errors++; $display("FAIL rmid_flags_after got %0d exp 0", (pe_cnt - b_pe) + (se_cnt - b_se));
        end
    endtask

    initial begin
        test_reset();
        test_good_p1();
        test_par_err();
        test_stop_err();
        test_glitch();
        test_midframe_cfg();
        test_back_to_back();
        test_reset_mid();
        checks++; if (pd_chg !== 0) begin errors++; $display("FAIL p_data_stable got %0d changes exp 0", pd_chg); end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
